wpa2_nios2_fast_cpu_div_cell: RTL
=================================

# wpa2_nios2_fast_cpu_div_cell

Iterative 32-bit integer divider serving the Nios II `div`/`divu` instructions; the inverse-direction companion of the CPU multiply cell. It accepts a dividend/divisor pair from the E stage and runs a fixed-latency radix-2 restoring algorithm. It then returns a quotient and remainder with a one-cycle done pulse. The pipeline stalls on `div_busy` until the result is consumed.

## Interface
- No parameters; operand width is fixed at 32.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `E_src1`  in  32  dividend.
- `E_src2`  in  32  divisor.
- `E_div_start`  in  1  start request; sampled only in IDLE.
- `E_div_signed`  in  1  1 = two's-complement (`div`), 0 = unsigned (`divu`); sampled with start.
- `div_busy`  out  1  high whenever state ≠ IDLE.
- `div_done`  out  1  one-cycle pulse; results valid in that cycle.
- `div_quotient`  out  32  quotient.
- `div_remainder`  out  32  remainder.
- `div_by_zero`  out  1  divisor was zero for the last completed operation.

## Operation
- States: IDLE → PREP → ITER → FIX → DONE → IDLE.
- **IDLE:** if `E_div_start`=1, capture `E_src1`, `E_src2` and `E_div_signed`, then go to PREP. Otherwise stay.
- **PREP (1 cycle):**
  - In signed mode, form the magnitudes |a| and |b| (32-bit unsigned; |0x80000000| = 0x80000000).
  - Record the quotient sign (sign a XOR sign b) and the remainder sign (sign a).
  - Record zero-divisor = (b == 0).
  - Load the 32-bit quotient shift register with |a|, clear the 33-bit partial remainder, set the 5-bit counter to 31, and go to ITER.
- **ITER (32 cycles):** each cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract |b| from the 33-bit partial remainder.
  - If the result is non-negative, keep the difference and set quotient LSB to 1; otherwise restore and set LSB to 0.
  - Decrement the counter. Leave to FIX when the counter reaches 0 after the final iteration.
- **FIX (1 cycle):**
  - If zero-divisor: quotient = 0xFFFFFFFF, remainder = captured `E_src1` (unmodified), `div_by_zero`=1. This holds in both modes.
  - Else: negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set. This gives truncation toward zero, with the remainder taking the dividend's sign. `div_by_zero`=0.
  - Register the results to the outputs and go to DONE.
- **DONE (1 cycle):** `div_done`=1, then go to IDLE.
- Output registers update only on the FIX→DONE edge and hold until the next completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0. No flag is raised.
- `E_div_start` while busy (including the DONE cycle) is ignored, not queued.
- Operand inputs may change freely after the start cycle.

## Timing
- `E_div_start` is sampled high in cycle 0. The block is in PREP in cycle 1, ITER in cycles 2–33, FIX in cycle 34, and DONE in cycle 35.
- `div_done`=1 in cycle 35 only. `div_busy`=1 in cycles 1–35.
- Latency is fixed at 35 cycles regardless of operand values, sign mode or zero divisor.
- The earliest next accepted start is cycle 36 (IDLE), giving a sustained throughput of one result per 36 cycles.
- Reset (synchronous, any state, including mid-ITER):
  - Next cycle the state is IDLE.
  - `div_busy`=0, `div_done`=0, `div_quotient`=0, `div_remainder`=0, `div_by_zero`=0.
  - The in-flight operation is discarded and no done pulse is produced.
- `reset` and `E_div_start` high in the same cycle: reset wins and the start is dropped.

## Test plan
- **Unsigned basic:** divu 100/7 → cycle 35 `div_done`=1, quotient 14, remainder 2, `div_by_zero`=0; `div_busy` high cycles 1–35.
- **Signed sign rules:**
  - −100/7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
  - 100/−7 → quotient 0xFFFFFFF2, remainder 2.
  - −100/−7 → quotient 14, remainder 0xFFFFFFFE.
- **Extremes:**
  - Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Unsigned same operands → quotient 0, remainder 0x80000000.
  - Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- **Divide by zero:** 0x12345678/0 in both modes → quotient 0xFFFFFFFF, remainder 0x12345678, `div_by_zero`=1, done still in cycle 35.
- **Handshake:**
  - Start pulses in cycles 5 and 35 are ignored, and outputs stay unchanged until cycle 35.
  - A new start in cycle 36 is accepted, with done in cycle 71.
  - Previous results remain stable on the outputs between completions.
- **Reset mid-op:** reset asserted in cycle 10 → cycle 11 `div_busy`=0 and all outputs 0, and no `div_done` appears in cycle 35. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/wpa2_nios2_fast_cpu_div_cell.sv
// wpa2_nios2_fast_cpu_div_cell: fixed-latency radix-2 restoring divider for Nios II div/divu.
module wpa2_nios2_fast_cpu_div_cell (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_src1,
    input  logic [31:0] E_src2,
    input  logic        E_div_start,
    input  logic        E_div_signed,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder,
    output logic        div_by_zero
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, quo_q, quo_d, bmag_q, bmag_d;
    logic [31:0] rem_q, rem_d, qout_q, qout_d, rout_q, rout_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, dbz_q, dbz_d;
    logic [32:0] shifted;
    logic        ge;
    // Partial remainder is always below |b|, so its 33rd bit only exists transiently in shifted.
    assign shifted = {rem_q, quo_q[31]};
    assign ge      = shifted >= {1'b0, bmag_q};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (E_div_start) begin
                a_d     = E_src1;
                b_d     = E_src2;
                sgn_d   = E_div_signed;
                state_d = PREP;
            end
            PREP: begin
                quo_d   = (sgn_q && a_q[31]) ? -a_q : a_q;
                bmag_d  = (sgn_q && b_q[31]) ? -b_q : b_q;
                qneg_d  = sgn_q & (a_q[31] ^ b_q[31]);
                rneg_d  = sgn_q & a_q[31];
                zero_d  = b_q == 32'd0;
                rem_d   = 32'd0;
                cnt_d   = 5'd31;
                state_d = ITER;
            end
            ITER: begin
                rem_d   = ge ? shifted[31:0] - bmag_q : shifted[31:0];
                quo_d   = {quo_q[30:0], ge};
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd0) ? FIX : ITER;
            end
            FIX: begin
                qout_d  = zero_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_q : quo_q);
                rout_d  = zero_q ? a_q : (rneg_q ? -rem_q : rem_q);
                dbz_d   = zero_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
        end
    end
    assign div_busy      = state_q != IDLE;
    assign div_done      = state_q == DONE;
    assign div_quotient  = qout_q;
    assign div_remainder = rout_q;
    assign div_by_zero   = dbz_q;
endmodule
